// File: rtl/pipe_flow_ctrl_pkg.sv
// pipe_flow_ctrl_pkg: frame FSM states and the occupancy width helper
package pipe_flow_ctrl_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    function automatic int occ_w(input int level);
        return $clog2(level + 1);
    endfunction
endpackage

// File: rtl/pipe_flow_ctrl_stage_ctl.sv
// stage_ctl: valid/last bits and load enable of a single pipeline stage
module stage_ctl (
    input  logic aclk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en_next,
    input  logic i_up_v,
    input  logic i_up_l,
    output logic o_en,
    output logic o_v,
    output logic o_l,
    output logic o_v_nxt
);
    logic r_v, r_l;
    assign o_en    = !r_v || i_en_next;
    assign o_v_nxt = (reset || i_clr) ? 1'b0 : o_en ? i_up_v : r_v;
    assign o_v     = r_v;
    assign o_l     = r_l;
    always_ff @(posedge aclk) begin
        if (reset || i_clr) begin
            r_v <= 1'b0;
            r_l <= 1'b0;
        end else if (o_en) begin
            r_v <= i_up_v;
            r_l <= i_up_l;
        end
    end
endmodule

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: bubble-collapsing valid/ready control for LEVEL data stages
// with a per-frame RUN/DRAIN/DONE sequencer and output beat counter.
module pipe_flow_ctrl
    import pipe_flow_ctrl_pkg::*;
#(
    parameter int LEVEL = 3,
    parameter int CNT_W = 16
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic [LEVEL-1:0]         stage_en,
    input  logic                     flush,
    output logic [occ_w(LEVEL)-1:0]  occupancy,
    output logic [CNT_W-1:0]         beat_count,
    output logic                     frame_done
);
    localparam int OW = occ_w(LEVEL);
    logic [LEVEL-1:0] w_v, w_l, w_v_nxt, w_up_v, w_up_l, w_en_next;
    logic [OW-1:0]    w_pop, r_occ;
    logic [CNT_W-1:0] r_cnt;
    logic             w_acc, w_hs;
    state_t           r_state;

    assign s_ready    = stage_en[0] && r_state == RUN && !flush && !reset;
    assign w_acc      = s_valid && s_ready;
    assign m_valid    = w_v[LEVEL-1];
    assign m_last     = w_l[LEVEL-1];
    assign w_hs       = m_valid && m_ready;
    assign occupancy  = r_occ;
    assign beat_count = r_cnt;
    assign frame_done = r_state == DONE;

    // The enable chain is flattened to "any free slot downstream" so no
    // enable depends combinationally on another enable.
    for (genvar i = 0; i < LEVEL; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign w_up_v[i] = w_acc;
            assign w_up_l[i] = s_last;
        end else begin : g_body
            assign w_up_v[i] = w_v[i-1];
            assign w_up_l[i] = w_l[i-1];
        end
        if (i == LEVEL - 1) begin : g_tail
            assign w_en_next[i] = m_ready;
        end else begin : g_inner
            assign w_en_next[i] = m_ready || !(&w_v[LEVEL-1:i+1]);
        end
        stage_ctl u_stage (
            .aclk      (aclk),
            .reset     (reset),
            .i_clr     (flush),
            .i_en_next (w_en_next[i]),
            .i_up_v    (w_up_v[i]),
            .i_up_l    (w_up_l[i]),
            .o_en      (stage_en[i]),
            .o_v       (w_v[i]),
            .o_l       (w_l[i]),
            .o_v_nxt   (w_v_nxt[i])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < LEVEL; k++) w_pop = w_pop + OW'(w_v_nxt[k]);
    end

    always_ff @(posedge aclk) begin
        if (reset || flush) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_occ   <= '0;
        end else begin
            r_occ   <= w_pop;
            r_cnt   <= r_state == DONE ? '0 : r_cnt + CNT_W'(w_hs);
            r_state <= r_state == RUN   ? (w_acc && s_last ? DRAIN : RUN) :
                       r_state == DRAIN ? (w_hs && m_last ? DONE : DRAIN) : RUN;
        end
    end
endmodule
